// File: rtl/e203_dsp_csa_resolve.sv
// Carry-save to binary resolver.
// One CW-bit adder is reused over the chunks, least significant first.
module e203_dsp_csa_resolve #(
  parameter int DW = 106,
  parameter int CW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_valid,
  output logic          i_ready,
  input  logic [DW-1:0] i_c,
  input  logic [DW-1:0] i_s,
  output logic          o_valid,
  input  logic          o_ready,
  output logic [DW-1:0] o_sum,
  output logic          o_cout
);

  localparam int NCH = (DW + CW - 1) / CW;
  localparam int TW  = DW - (NCH - 1) * CW;
  localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } st_t;

  st_t           st;
  st_t           st_nxt;
  logic [DW-1:0] c_q;
  logic [DW-1:0] s_q;
  logic [KW-1:0] k;
  logic          cy;
  logic          last;
  int            sh;
  logic [CW-1:0] ca;
  logic [CW-1:0] sa;
  logic [CW:0]   add;
  logic [DW-1:0] msk;
  logic [DW-1:0] ins;

  // Chunk slicing and the shared adder; the top chunk is
  // zero-extended because the shift brings in zeros above DW.
  always_comb begin
    sh   = CW * int'(k);
    ca   = CW'(c_q >> sh);
    sa   = CW'(s_q >> sh);
    add  = {1'b0, ca} + {1'b0, sa} + {{CW{1'b0}}, cy};
    last = (k == KW'(NCH - 1));
    msk  = DW'({CW{1'b1}}) << sh;
    ins  = DW'(add[CW-1:0]) << sh;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= IDLE;
    else        st <= st_nxt;
  end

  // Next-state logic.
  always_comb begin
    st_nxt = st;
    unique case (st)
      IDLE:    if (i_valid) st_nxt = BUSY;
      BUSY:    if (last)    st_nxt = DONE;
      DONE:    if (o_ready) st_nxt = IDLE;
      default: st_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    i_ready = (st == IDLE);
    o_valid = (st == DONE);
  end

  // Operand capture and chunk-by-chunk result assembly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q    <= '0;
      s_q    <= '0;
      k      <= '0;
      cy     <= 1'b0;
      o_sum  <= '0;
      o_cout <= 1'b0;
    end else begin
      unique case (st)
        IDLE: begin
          if (i_valid) begin
            c_q <= i_c;
            s_q <= i_s;
            k   <= '0;
            cy  <= 1'b0;
          end
        end
        BUSY: begin
          o_sum <= (o_sum & ~msk) | ins;
          cy    <= add[CW];
          k     <= k + KW'(1);
          if (last) o_cout <= add[TW];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/e203_dsp_csa_resolve.md
E203_DSP_CSA_RESOLVE -- requirements
Module: e203_dsp_csa_resolve

Interface
REQ-001 Parameter: DW, default 106, operand and result width in bits.
REQ-002 Parameter: CW, default 32, chunk width added per cycle; 1 <= CW <= DW.
REQ-003 Derived: NCH = ceil(DW/CW), number of chunks (4 at defaults); top chunk width DW-(NCH-1)*CW (10 at defaults).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 i_valid  input  1  carry-save pair offered.
REQ-007 i_ready  output  1  block can accept a pair.
REQ-008 i_c  input  DW  carry vector; no assumption on i_c[0].
REQ-009 i_s  input  DW  save vector.
REQ-010 o_valid  output  1  resolved result available.
REQ-011 o_ready  input  1  downstream accepts the result.
REQ-012 o_sum  output  DW  (i_c + i_s) mod 2^DW.
REQ-013 o_cout  output  1  bit DW of the full i_c + i_s.

Function
REQ-014 The block shall convert one carry-save pair into binary form with a CW-bit adder used iteratively, least-significant chunk first.
REQ-015 FSM states shall be IDLE, BUSY and DONE; encoding is free.
REQ-016 i_ready shall be 1 only in IDLE; o_valid shall be 1 only in DONE.
REQ-017 IDLE: on i_valid=1, the block shall register i_c and i_s, clear the chunk index and carry register, and go to BUSY; otherwise it stays in IDLE.
REQ-018 BUSY: each cycle it shall add chunk k of both registered vectors plus the carry register, write the CW-bit result into o_sum chunk k, store the chunk carry-out, and increment k.
REQ-019 The top chunk shall be zero-extended to CW bits; its carry-out shall go to bit (DW-(NCH-1)*CW) of the zero-extended add, and that bit shall be o_cout.
REQ-020 After chunk NCH-1 is processed, the FSM shall go to DONE.
REQ-021 Latency: o_valid shall rise exactly NCH cycles after the accepting edge (4 at defaults).
REQ-022 DONE: o_sum and o_cout shall stay stable while o_ready=0. On o_ready=1 the FSM shall return to IDLE.
REQ-023 There is no acceptance in DONE. The earliest next accept is the cycle after the output handshake, so minimum throughput is one pair per NCH+2 cycles.
REQ-024 Inputs shall be ignored outside IDLE; changes on i_c, i_s or i_valid during BUSY or DONE shall not affect the result.
REQ-025 If NCH=1, BUSY shall last one cycle.
REQ-026 o_sum chunks not yet written in BUSY are don't-care; only values qualified by o_valid are architectural.

Reset
REQ-027 While rst_n=0, the FSM shall be in IDLE, with i_ready=1 and o_valid=0.
REQ-028 While rst_n=0, o_sum, o_cout, the carry register, the chunk index and the operand registers shall be 0.
REQ-029 Reset asserted during BUSY or DONE shall drop the in-flight pair with no output handshake.
REQ-030 The first accept after reset deassertion shall be allowed on the first rising edge with rst_n=1 and i_valid=1.

Verification
REQ-031 Basic add: i_c=0, i_s=5 accepted -> after 4 cycles o_valid=1, o_sum=5, o_cout=0.
REQ-032 Chunk-boundary carry: i_s=2^32-1, i_c=1 -> o_sum=2^32, o_cout=0.
REQ-033 Full-width carry: i_s=2^106-1, i_c=1 -> o_sum=0, o_cout=1.
REQ-034 Backpressure: i_c=3, i_s=4 with o_ready=0 for 3 cycles after o_valid -> o_sum=7 held stable. Toggling i_c and i_s during the hold has no effect. One transfer occurs when o_ready=1.
REQ-035 Reset mid-operation: rst_n pulled low 2 cycles after accept -> o_valid never asserts, i_ready=1 at once. A following pair i_c=10, i_s=20 gives o_sum=30.
REQ-036 Back-to-back: i_valid held high with two pairs (1,2) then (100,200), o_ready=1 -> results 3 then 300, accepts spaced 6 cycles apart.
